key_event: RTL and testbench



---
 rtl/key_pkg.sv | 12 +
 rtl/key_event_if.sv | 17 +
 rtl/key_edge.sv | 26 ++
 rtl/key_event.sv | 89 ++++++++
 tb/tb_key_event.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and timing defaults for key gesture detection.
//   Provides the FSM state enum, the 12 MHz clock / gesture timing defaults,
//   and ms_to_clk() to turn millisecond timings into clock counts.
package key_pkg;
    typedef enum logic [2:0] {IDLE, PRESS1, HOLD, GAP, PRESS2} state_t;
    localparam int CLK_HZ    = 12000000;
    localparam int LONG_MS   = 1000;
    localparam int DCLICK_MS = 300;
    function automatic int ms_to_clk(input int ms);
        return int'(64'(CLK_HZ) * 64'(ms) / 64'd1000);
    endfunction
endpackage

// File: rtl/key_event_if.sv
// key_event_if: key level in, gesture pulses and status out.
//   key_i     - debounced key level
//   short_o   - single short press pulse
//   double_o  - double click pulse
//   long_o    - long press pulse
//   pressed_o - registered, polarity-normalised key level
//   busy_o    - gesture in progress
interface key_event_if;
    logic key_i;
    logic short_o;
    logic double_o;
    logic long_o;
    logic pressed_o;
    logic busy_o;
    modport master(output key_i, input short_o, double_o, long_o, pressed_o, busy_o);
    modport slave(input key_i, output short_o, double_o, long_o, pressed_o, busy_o);
endinterface

// File: rtl/key_edge.sv
// key_edge: normalises key polarity, registers the pressed level, flags press/release edges.
//   sys_clk, sys_rst_n - clock and asynchronous active-low reset
//   i_key              - debounced key level
//   o_pressed          - registered level, 1 = pressed (resets to released)
//   o_press_e/o_rel_e  - combinational press/release edge of the current sample
module key_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key,
    output logic o_pressed,
    output logic o_press_e,
    output logic o_rel_e
);
    logic w_p;
    logic r_pressed;
    assign w_p = i_key ^ ACTIVE_LOW;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_pressed <= 1'b0;
        else            r_pressed <= w_p;
    end
    assign o_pressed = r_pressed;
    assign o_press_e = w_p & ~r_pressed;
    assign o_rel_e   = ~w_p & r_pressed;
endmodule

// File: rtl/key_event.sv
// key_event: classifies key gestures into short / double / long single-cycle pulses.
//   sys_clk, sys_rst_n - 12 MHz clock and asynchronous active-low reset
//   io_bus             - key level in, registered pulses and status out
module key_event
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int LONG_TIME   = ms_to_clk(LONG_MS),
    parameter int DCLICK_TIME = ms_to_clk(DCLICK_MS),
    parameter int CNT_BITS    = 24
) (
    input logic         sys_clk,
    input logic         sys_rst_n,
    key_event_if.slave  io_bus
);
    localparam logic [CNT_BITS-1:0] LONG_LAST   = CNT_BITS'(LONG_TIME - 1);
    localparam logic [CNT_BITS-1:0] DCLICK_LAST = CNT_BITS'(DCLICK_TIME - 1);
    logic                w_press_e;
    logic                w_rel_e;
    logic                w_pressed;
    state_t              r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_short;
    logic                r_double;
    logic                r_long;
    logic                r_busy;
    key_edge #(.ACTIVE_LOW(ACTIVE_LOW)) u_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_key     (io_bus.key_i),
        .o_pressed (w_pressed),
        .o_press_e (w_press_e),
        .o_rel_e   (w_rel_e)
    );
    // Edge events take priority over timeouts; counting states always leave at
    // their threshold, so the counter never wraps.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            case (r_state)
                IDLE: if (w_press_e) begin
                    r_state <= PRESS1;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                PRESS1: if (w_rel_e) begin
                    r_state <= GAP;
                    r_cnt   <= '0;
                end else if (r_cnt == LONG_LAST) begin
                    r_long  <= 1'b1;
                    r_state <= HOLD;
                end else r_cnt <= r_cnt + 1'b1;
                HOLD: if (w_rel_e) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                GAP: if (w_press_e) r_state <= PRESS2;
                else if (r_cnt == DCLICK_LAST) begin
                    r_short <= 1'b1;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else r_cnt <= r_cnt + 1'b1;
                PRESS2: if (w_rel_e) begin
                    r_double <= 1'b1;
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
    assign io_bus.short_o   = r_short;
    assign io_bus.double_o  = r_double;
    assign io_bus.long_o    = r_long;
    assign io_bus.pressed_o = w_pressed;
    assign io_bus.busy_o    = r_busy;
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: checks both key polarities against a gesture-level reference model.
module tb_key_event;
    localparam int L = 20;
    localparam int D = 10;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    key_event_if ia();
    key_event_if ib();
    key_event #(.ACTIVE_LOW(1'b1), .LONG_TIME(L), .DCLICK_TIME(D), .CNT_BITS(24)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .io_bus(ia.slave));
    key_event #(.ACTIVE_LOW(1'b0), .LONG_TIME(L), .DCLICK_TIME(D), .CNT_BITS(24)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .io_bus(ib.slave));
    int errors = 0;
    int checks = 0;
    bit         p_q[$];
    logic [4:0] obs_a[$];
    logic [4:0] obs_b[$];
    logic [4:0] exp_q[$];

    task automatic add(bit lvl, int n);
        repeat (n) p_q.push_back(lvl);
    endtask

    task automatic drive(bit p);
        ia.key_i = ~p;
        ib.key_i = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0);
        p_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int run_len(int s, bit lvl);
        int k = s;
        while (k < p_q.size() && p_q[k] == lvl) k++;
        return k - s;
    endfunction

    // Gesture-level model: walks press/release runs of the sampled trace
    // (one entry per clock edge, history released at trace start).
    task automatic model();
        int n, t, t0, len, r, g, s, e;
        bit sh[], db[], lg[], by[];
        n = p_q.size();
        sh = new[n]; db = new[n]; lg = new[n]; by = new[n];
        t = 0;
        while (t < n) begin
            if (!p_q[t]) begin
                t++;
                continue;
            end
            t0 = t;
            len = run_len(t0, 1'b1);
            if (len > L) begin
                lg[t0 + L] = 1'b1;
                e = t0 + len;
            end else begin
                r = t0 + len;
                if (r >= n) e = n;
                else begin
                    g = run_len(r, 1'b0);
                    if (g > D) begin
                        sh[r + D] = 1'b1;
                        e = r + D;
                    end else if (r + g >= n) e = n;
                    else begin
                        s = r + g;
                        e = s + run_len(s, 1'b1);
                        if (e < n) db[e] = 1'b1;
                    end
                end
            end
            for (int k = t0; k < e; k++) by[k] = 1'b1;
            t = e;
        end
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({sh[i], db[i], lg[i], p_q[i], by[i]});
    endtask

    task automatic play();
        obs_a.delete();
        obs_b.delete();
        foreach (p_q[i]) begin
            drive(p_q[i]);
            @(posedge clk);
            #1;
            obs_a.push_back({ia.short_o, ia.double_o, ia.long_o, ia.pressed_o, ia.busy_o});
            obs_b.push_back({ib.short_o, ib.double_o, ib.long_o, ib.pressed_o, ib.busy_o});
        end
        model();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ia.short_o, ia.double_o, ia.long_o, ia.pressed_o, ia.busy_o,
             ib.short_o, ib.double_o, ib.long_o, ib.pressed_o, ib.busy_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold got a=%b b=%b expected 00000",
                {ia.short_o, ia.double_o, ia.long_o, ia.pressed_o, ia.busy_o},
                {ib.short_o, ib.double_o, ib.long_o, ib.pressed_o, ib.busy_o});
        end
        rst_n = 1'b1;
        p_q.delete();
        add(1'b0, 50);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL reset_idle al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL reset_idle al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_short();
        do_reset();
        add(1'b0, 3); add(1'b1, 5); add(1'b0, 20);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL short al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL short al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_double();
        do_reset();
        add(1'b0, 2); add(1'b1, 5); add(1'b0, 4); add(1'b1, 3); add(1'b0, 15);
        add(1'b1, 2); add(1'b0, 2); add(1'b1, 30); add(1'b0, 15);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL double al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL double al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_long();
        do_reset();
        add(1'b0, 2); add(1'b1, 40); add(1'b0, 20);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL long al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL long al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_boundary_long();
        do_reset();
        add(1'b0, 2); add(1'b1, L); add(1'b0, 20);
        add(1'b1, L + 1); add(1'b0, 20);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL bound_long al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL bound_long al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_boundary_gap();
        do_reset();
        add(1'b0, 2); add(1'b1, 4); add(1'b0, D); add(1'b1, 3); add(1'b0, 15);
        add(1'b1, 4); add(1'b0, D + 1); add(1'b1, 3); add(1'b0, 15);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL bound_gap al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL bound_gap al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        add(1'b0, 2); add(1'b1, 10);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL abort_pre al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL abort_pre al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ia.short_o, ia.double_o, ia.long_o, ia.pressed_o, ia.busy_o,
             ib.short_o, ib.double_o, ib.long_o, ib.pressed_o, ib.busy_o} !== 10'b0) begin
            errors++;
            $display("FAIL abort_async got a=%b b=%b expected 00000",
                {ia.short_o, ia.double_o, ia.long_o, ia.pressed_o, ia.busy_o},
                {ib.short_o, ib.double_o, ib.long_o, ib.pressed_o, ib.busy_o});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        p_q.delete();
        add(1'b1, 6); add(1'b0, 20);
        play();
        foreach (exp_q[i]) begin
            checks += 2;
            if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL abort_post al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
            if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL abort_post al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        repeat (6) begin
            do_reset();
            repeat (8) begin
                add(1'b1, int'($urandom_range(1, 26)));
                add(1'b0, int'($urandom_range(1, 14)));
            end
            add(1'b0, 20);
            play();
            foreach (exp_q[i]) begin
                checks += 2;
                if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL random al1 cycle %0d got %b expected %b", i, obs_a[i], exp_q[i]); end
                if (obs_b[i] !== exp_q[i]) begin errors++; $display("FAIL random al0 cycle %0d got %b expected %b", i, obs_b[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        drive(1'b0);
        test_reset();
        test_short();
        test_double();
        test_long();
        test_boundary_long();
        test_boundary_gap();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
